// File: rtl/spi_mmio_pkg.sv
// Shared register offsets and shift-engine states for the MMIO SPI master.
package spi_mmio_pkg;

    localparam logic [11:0] OFS_SCKDIV = 12'h000;
    localparam logic [11:0] OFS_CSCTL  = 12'h018;
    localparam logic [11:0] OFS_TXDATA = 12'h048;
    localparam logic [11:0] OFS_RXDATA = 12'h04c;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH
    } spi_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through output; pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LGDEPTH = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   dout,
    output logic               full,
    output logic               empty,
    output logic [LGDEPTH:0]   count
);

    localparam int unsigned DEPTH = 1 << LGDEPTH;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [LGDEPTH-1:0] wptr_q, rptr_q;
    logic [LGDEPTH:0]   cnt_q;
    logic               do_push, do_pop;

    assign full    = (cnt_q == (LGDEPTH + 1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign dout    = mem_q[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + {{LGDEPTH{1'b0}}, do_push} - {{LGDEPTH{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/spi_mmio_master.sv
// Memory-mapped SPI master (mode 0, MSB first) with TX/RX FIFOs, SCK divider and software chip select.
module spi_mmio_master
    import spi_mmio_pkg::*;
#(
    parameter logic [31:0] BASE       = 32'h10024000,
    parameter int unsigned LGDEPTH    = 3,
    parameter logic [11:0] SCKDIV_RST = 12'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rq_en,
    input  logic [31:0] rq_addr,
    input  logic        rq_iswrite,
    input  logic [31:0] rq_data,
    output logic        rs_en,
    output logic [31:0] rs_data,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_csn
);

    logic        hit, wr, rd;
    logic [11:0] ofs;
    logic        rs_en_q;
    logic [31:0] rs_data_q, rdata;
    logic [11:0] sckdiv_q;
    logic        csn_q, ovf_q;

    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic        rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]  tx_dout, rx_dout;
    logic [LGDEPTH:0] tx_cnt, rx_cnt;

    spi_state_e  state_q, state_d;
    logic [11:0] divcnt_q, divcnt_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  rxsh_q, rxsh_d;
    logic        sck_q, sck_d;
    logic        load;

    logic unused_bits;
    assign unused_bits = ^{rq_data[31:12], tx_cnt, rx_cnt};

    assign hit = rq_en && (rq_addr[31:12] == BASE[31:12]);
    assign ofs = rq_addr[11:0];
    assign wr  = hit && rq_iswrite;
    assign rd  = hit && !rq_iswrite;

    assign tx_push = wr && (ofs == OFS_TXDATA);
    assign rx_pop  = rd && (ofs == OFS_RXDATA);

    assign rs_en    = rs_en_q;
    assign rs_data  = rs_data_q;
    assign spi_clk  = sck_q;
    assign spi_mosi = shreg_q[7];
    assign spi_csn  = csn_q;

    sync_fifo #(.WIDTH(8), .LGDEPTH(LGDEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .din(rq_data[7:0]),
        .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_cnt)
    );

    sync_fifo #(.WIDTH(8), .LGDEPTH(LGDEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .din(rxsh_q),
        .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_cnt)
    );

    always_comb begin
        rdata = '0;
        case (ofs)
            OFS_SCKDIV: rdata = {20'b0, sckdiv_q};
            OFS_CSCTL:  rdata = {30'b0, !csn_q, 1'b0};
            OFS_TXDATA: rdata = {tx_full, 31'b0};
            OFS_RXDATA: rdata = rx_empty ? {1'b1, ovf_q, 30'b0} : {1'b0, ovf_q, 22'b0, rx_dout};
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rs_en_q   <= 1'b0;
            rs_data_q <= '0;
            sckdiv_q  <= SCKDIV_RST;
            csn_q     <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            rs_en_q   <= hit;
            rs_data_q <= rd ? rdata : '0;
            if (wr && ofs == OFS_SCKDIV) sckdiv_q <= rq_data[11:0];
            if (wr && ofs == OFS_CSCTL)  csn_q    <= !rq_data[1];
            if (rx_push && rx_full)      ovf_q    <= 1'b1;
        end
    end

    // MOSI is shreg[7]; the last byte's LSB stays on the line while idle.
    always_comb begin
        state_d  = state_q;
        divcnt_d = divcnt_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        rxsh_d   = rxsh_q;
        sck_d    = sck_q;
        tx_pop   = 1'b0;
        rx_push  = 1'b0;
        load     = 1'b0;
        case (state_q)
            ST_IDLE: load = !tx_empty;
            ST_LOW: begin
                if (divcnt_q != '0) begin
                    divcnt_d = divcnt_q - 12'd1;
                end else begin
                    sck_d    = 1'b1;
                    rxsh_d   = {rxsh_q[6:0], spi_miso};
                    divcnt_d = sckdiv_q;
                    state_d  = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (divcnt_q != '0) begin
                    divcnt_d = divcnt_q - 12'd1;
                end else begin
                    sck_d = 1'b0;
                    if (bitcnt_q != '0) begin
                        shreg_d  = {shreg_q[6:0], 1'b0};
                        bitcnt_d = bitcnt_q - 3'd1;
                        divcnt_d = sckdiv_q;
                        state_d  = ST_LOW;
                    end else begin
                        rx_push = 1'b1;
                        load    = !tx_empty;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Back-to-back bytes reload straight from HIGH without passing through IDLE.
        if (load) begin
            tx_pop   = 1'b1;
            shreg_d  = tx_dout;
            bitcnt_d = 3'd7;
            divcnt_d = sckdiv_q;
            state_d  = ST_LOW;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            divcnt_q <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            rxsh_q   <= '0;
            sck_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            divcnt_q <= divcnt_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            rxsh_q   <= rxsh_d;
            sck_q    <= sck_d;
        end
    end

endmodule
